// File: rtl/fd_pkg.sv
// rtl/fd_pkg.sv - shared widths, corner-entry record and clog2 helper for the corner collector
package fd_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int PIX_W_DEF  = 8;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [PIX_W_DEF-1:0]  pixel;
    } corner_entry_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fd_sync_fifo.sv
// rtl/fd_sync_fifo.sv - single-clock FIFO with wrap-bit pointers, flush, and push-through-when-full-with-pop
module fd_sync_fifo
    import fd_pkg::*;
#(
    parameter int WIDTH = 23,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             wr_en;
    logic [AW-1:0]    waddr;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata = mem_q[rptr_q[AW-1:0]];

    // A flush restarts both pointers; a push in the same cycle lands in slot 0.
    always_comb begin
        wr_en  = push && (flush || !full || pop);
        waddr  = flush ? '0 : wptr_q[AW-1:0];
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            rptr_d = '0;
            wptr_d = push ? PTR_ONE : '0;
        end else begin
            if (wr_en) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (pop && !empty) begin
                rptr_d = rptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/fd_corner_collector.sv
// rtl/fd_corner_collector.sv - queues detected corners with skew-corrected addresses and keeps per-frame counts
module fd_corner_collector
    import fd_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int PIX_W       = PIX_W_DEF,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 16,
    parameter int ADDR_OFFSET = 1
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              frameStart,
    input  logic              isCorner,
    input  logic [ADDR_W-1:0] refAddr,
    input  logic [PIX_W-1:0]  refPixel,
    output logic              outValid,
    input  logic              outReady,
    output logic [ADDR_W-1:0] outAddr,
    output logic [PIX_W-1:0]  outPixel,
    output logic [CNT_W-1:0]  cornerCount,
    output logic [CNT_W-1:0]  dropCount,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] ADDR_SKEW = ADDR_W'(ADDR_OFFSET);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    drop;
    logic [ADDR_W+PIX_W-1:0] wdata;
    logic [ADDR_W+PIX_W-1:0] rdata;
    logic [CNT_W-1:0]        corner_cnt_q, corner_cnt_d;
    logic [CNT_W-1:0]        drop_cnt_q, drop_cnt_d;
    logic                    overflow_q, overflow_d;

    assign pop      = outReady && !fifo_empty;
    assign outValid = !fifo_empty;
    assign wdata    = {refAddr - ADDR_SKEW, refPixel};
    assign outAddr  = rdata[ADDR_W+PIX_W-1:PIX_W];
    assign outPixel = rdata[PIX_W-1:0];

    // A corner is lost only when the FIFO is full and the head is not leaving this cycle.
    assign drop = isCorner && !frameStart && fifo_full && !pop;

    fd_sync_fifo #(
        .WIDTH (ADDR_W + PIX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock  (clock),
        .nReset (nReset),
        .push   (isCorner),
        .pop    (pop),
        .flush  (frameStart),
        .wdata  (wdata),
        .rdata  (rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        corner_cnt_d = corner_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        overflow_d   = overflow_q;
        if (frameStart) begin
            corner_cnt_d = isCorner ? CNT_ONE : '0;
            drop_cnt_d   = '0;
            overflow_d   = 1'b0;
        end else begin
            if (isCorner && (corner_cnt_q != CNT_MAX)) begin
                corner_cnt_d = corner_cnt_q + CNT_ONE;
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != CNT_MAX) begin
                    drop_cnt_d = drop_cnt_q + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            corner_cnt_q <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            corner_cnt_q <= corner_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    assign cornerCount = corner_cnt_q;
    assign dropCount   = drop_cnt_q;
    assign overflow    = overflow_q;

endmodule
